// File: rtl/bp_adh_pkg.sv
// rtl/bp_adh_pkg.sv - shared constants and FSM encoding for the BP estimator
package bp_adh_pkg;

  localparam logic [5:0] BP_LO      = 6'd20;
  localparam logic [5:0] BP_HI      = 6'd45;
  localparam logic [8:0] ADH_CLAMP  = 9'd100;
  localparam logic [8:0] ADH_OFFSET = 9'd180;

  localparam logic [1:0] TREND_FLAT = 2'b00;
  localparam logic [1:0] TREND_UP   = 2'b01;
  localparam logic [1:0] TREND_DOWN = 2'b10;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/adh_to_bp.sv
// rtl/adh_to_bp.sv - combinational per-sample ADH to BP mapping with clamp flags
module adh_to_bp
  import bp_adh_pkg::*;
(
  input  logic [8:0] adh,
  output logic [5:0] bp,
  output logic       clamp_lo,
  output logic       clamp_hi
);

  always_comb begin
    clamp_lo = (adh >= ADH_CLAMP);
    clamp_hi = (adh == 9'd0);
    if (clamp_lo) begin
      bp = BP_LO;
    end else if (clamp_hi) begin
      bp = BP_HI;
    end else begin
      // divide by four as a shift; 180-adh fits 8 bits for adh in 1..99
      bp = 6'((ADH_OFFSET - adh) >> 2);
    end
  end

endmodule

// File: rtl/bp_estimator.sv
// rtl/bp_estimator.sv - windowed BP average from ADH samples; trend output under BP_EST_TREND_EN
module bp_estimator
  import bp_adh_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] adh_in,
  input  logic       adh_valid,
  output logic       adh_ready,
  output logic [8:0] bp_out,
  output logic       bp_valid,
  input  logic       bp_ready,
  output logic       sat_lo,
  output logic       sat_hi
`ifdef BP_EST_TREND_EN
  ,
  output logic [1:0] bp_trend
`endif
);

  localparam int ACC_W = 9 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_sum;
  logic [CNT_W-1:0]   cnt;
  logic               win_lo;
  logic               win_hi;
  logic [5:0]         s_bp;
  logic               s_lo;
  logic               s_hi;
  logic [8:0]         avg;
  logic               take;

`ifdef BP_EST_TREND_EN
  logic [8:0]         prev_avg;
  logic               first_win;
`endif

  adh_to_bp u_map (
    .adh      (adh_in),
    .bp       (s_bp),
    .clamp_lo (s_lo),
    .clamp_hi (s_hi)
  );

  assign take    = (state == COLLECT) && adh_valid && adh_ready;
  assign acc_sum = acc + ACC_W'(s_bp);
  assign avg     = 9'(acc_sum >> AVG_LOG2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      acc       <= '0;
      cnt       <= '0;
      win_lo    <= 1'b0;
      win_hi    <= 1'b0;
      adh_ready <= 1'b0;
      bp_out    <= '0;
      bp_valid  <= 1'b0;
      sat_lo    <= 1'b0;
      sat_hi    <= 1'b0;
`ifdef BP_EST_TREND_EN
      bp_trend  <= TREND_FLAT;
      prev_avg  <= '0;
      first_win <= 1'b1;
`endif
    end else begin
      case (state)
        COLLECT: begin
          adh_ready <= 1'b1;
          if (take) begin
            if (cnt == LAST) begin
              // window complete: the final sample is folded straight into the result
              state     <= PRESENT;
              adh_ready <= 1'b0;
              bp_valid  <= 1'b1;
              bp_out    <= avg;
              sat_lo    <= win_lo | s_lo;
              sat_hi    <= win_hi | s_hi;
              acc       <= acc_sum;
`ifdef BP_EST_TREND_EN
              if (first_win)           bp_trend <= TREND_FLAT;
              else if (avg > prev_avg) bp_trend <= TREND_UP;
              else if (avg < prev_avg) bp_trend <= TREND_DOWN;
              else                     bp_trend <= TREND_FLAT;
              prev_avg  <= avg;
              first_win <= 1'b0;
`endif
            end else begin
              acc    <= acc_sum;
              cnt    <= cnt + 1'b1;
              win_lo <= win_lo | s_lo;
              win_hi <= win_hi | s_hi;
            end
          end
        end
        PRESENT: begin
          if (bp_ready) begin
            state     <= COLLECT;
            bp_valid  <= 1'b0;
            adh_ready <= 1'b1;
            sat_lo    <= 1'b0;
            sat_hi    <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            win_lo    <= 1'b0;
            win_hi    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_estimator.sv
// tb/tb_bp_estimator.sv - directed self-checking bench for bp_estimator
module tb_bp_estimator;

  logic       clk;
  logic       rst_n;
  logic [8:0] adh_in;
  logic       adh_valid;
  logic       adh_ready;
  logic [8:0] bp_out;
  logic       bp_valid;
  logic       bp_ready;
  logic       sat_lo;
  logic       sat_hi;
`ifdef BP_EST_TREND_EN
  logic [1:0] bp_trend;
`endif

  int total = 0;
  int bad   = 0;

  bp_estimator #(.AVG_LOG2(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .adh_in    (adh_in),
    .adh_valid (adh_valid),
    .adh_ready (adh_ready),
    .bp_out    (bp_out),
    .bp_valid  (bp_valid),
    .bp_ready  (bp_ready),
    .sat_lo    (sat_lo),
    .sat_hi    (sat_hi)
`ifdef BP_EST_TREND_EN
    ,
    .bp_trend  (bp_trend)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [8:0] a);
    int n;
    adh_in    = a;
    adh_valid = 1'b1;
    n = 0;
    while (adh_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'(adh_ready), 32'd1);
    @(posedge clk);
    #1;
    adh_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input int exp_bp, input bit lo, input bit hi,
                              input logic [1:0] tr);
    $display("window %s: expect avg=%0d trend=%0d", tag, exp_bp, tr);
    chk({tag, ".valid"},  32'(bp_valid),  32'd1);
    chk({tag, ".bp_out"}, 32'(bp_out),    32'(exp_bp));
    chk({tag, ".sat_lo"}, 32'(sat_lo),    32'(lo));
    chk({tag, ".sat_hi"}, 32'(sat_hi),    32'(hi));
    chk({tag, ".ready"},  32'(adh_ready), 32'd0);
`ifdef BP_EST_TREND_EN
    chk({tag, ".trend"},  32'(bp_trend),  32'(tr));
`endif
  endtask

  task automatic accept(input string tag);
    bp_ready = 1'b1;
    @(posedge clk);
    #1;
    bp_ready = 1'b0;
    chk({tag, ".acc_valid"}, 32'(bp_valid),  32'd0);
    chk({tag, ".acc_ready"}, 32'(adh_ready), 32'd1);
  endtask

  task automatic window(input string tag, input logic [8:0] a, input int exp_bp,
                        input bit lo, input bit hi, input logic [1:0] tr);
    repeat (4) send(a);
    check_result(tag, exp_bp, lo, hi, tr);
    accept(tag);
  endtask

  initial begin
    rst_n     = 1'b1;
    adh_in    = '0;
    adh_valid = 1'b0;
    bp_ready  = 1'b0;

    // reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst.valid",  32'(bp_valid),  32'd0);
    chk("rst.bp_out", 32'(bp_out),    32'd0);
    chk("rst.ready",  32'(adh_ready), 32'd0);
    chk("rst.sat_lo", 32'(sat_lo),    32'd0);
    chk("rst.sat_hi", 32'(sat_hi),    32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rel.ready0", 32'(adh_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rel.ready1", 32'(adh_ready), 32'd1);

    // mixed window: 20+45+30+40 = 135 -> 33
    send(9'd100);
    send(9'd0);
    send(9'd60);
    chk("mix.not_yet", 32'(bp_valid), 32'd0);
    send(9'd20);
    check_result("mix", 33, 1'b1, 1'b1, 2'b00);
    accept("mix");

    // boundaries
    window("adh1",   9'd1,   44, 1'b0, 1'b0, 2'b01);
    window("adh99",  9'd99,  20, 1'b0, 1'b0, 2'b10);
    window("adh511", 9'd511, 20, 1'b1, 1'b0, 2'b00);

    // backpressure with extra samples offered while presenting
    repeat (4) send(9'd60);
    check_result("bp", 30, 1'b0, 1'b0, 2'b01);
    adh_in    = 9'd0;
    adh_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp.hold_valid", 32'(bp_valid),  32'd1);
      chk("bp.hold_out",   32'(bp_out),    32'd30);
      chk("bp.hold_ready", 32'(adh_ready), 32'd0);
      chk("bp.hold_hi",    32'(sat_hi),    32'd0);
    end
    bp_ready = 1'b1;
    @(posedge clk);
    #1;
    bp_ready  = 1'b0;
    adh_valid = 1'b0;
    chk("bp.hs_valid", 32'(bp_valid),  32'd0);
    chk("bp.hs_ready", 32'(adh_ready), 32'd1);
    window("bp_next", 9'd20, 40, 1'b0, 1'b0, 2'b01);

    // reset mid-window discards the two ADH 0 samples
    send(9'd0);
    send(9'd0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid.valid",  32'(bp_valid),  32'd0);
    chk("mid.bp_out", 32'(bp_out),    32'd0);
    chk("mid.ready",  32'(adh_ready), 32'd0);
    chk("mid.sat_hi", 32'(sat_hi),    32'd0);
    #2 rst_n = 1'b1;
    window("mid_next", 9'd20, 40, 1'b0, 1'b0, 2'b00);

    // clean reset, then trend sequence 30, 40, 30
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    chk("rst2.bp_out", 32'(bp_out), 32'd0);
    window("tr1", 9'd60, 30, 1'b0, 1'b0, 2'b00);
    window("tr2", 9'd20, 40, 1'b0, 1'b0, 2'b01);
    window("tr3", 9'd60, 30, 1'b0, 1'b0, 2'b10);

    // sparse source
    for (int i = 0; i < 4; i++) begin
      send(9'd60);
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    check_result("sparse", 30, 1'b0, 1'b0, 2'b00);
    accept("sparse");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
